// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch and the
// load/store stage. Data wins ties; one access is in flight at a time.
module mem_port_arbiter #(
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [11:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic [1:0]  mem_rw_i,
   input  logic [11:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_rdata,
   output logic        mem_ack,
   output logic        stallreq_if,
   output logic        stallreq_mem,
   output logic        ram_en,
   output logic [3:0]  ram_we,
   output logic [9:0]  ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] LAT_C = 3'(LATENCY);

   state_t      state_r;
   logic [2:0]  cnt_r;
   logic        owner_data_r;
   logic        capture_r;
   logic        data_valid_s;
   logic        unused_addr_lsb_s;

   // Opcode 11 is treated exactly like 00: no request.
   assign data_valid_s      = (mem_rw_i == 2'b01) || (mem_rw_i == 2'b10);
   assign stallreq_if       = if_req & ~if_ack & ~rst;
   assign stallreq_mem      = data_valid_s & ~mem_ack & ~rst;
   assign unused_addr_lsb_s = ^{if_addr[1:0], mem_addr_i[1:0]};

   // Access sequencer: grant in IDLE, strobe in ISSUE, latency wait, ack in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 3'd0;
         owner_data_r <= 1'b0;
         capture_r    <= 1'b0;
         if_rdata     <= 32'd0;
         mem_rdata    <= 32'd0;
         if_ack       <= 1'b0;
         mem_ack      <= 1'b0;
         ram_en       <= 1'b0;
         ram_we       <= 4'd0;
         ram_addr     <= 10'd0;
         ram_wdata    <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (data_valid_s) begin
                  owner_data_r <= 1'b1;
                  capture_r    <= (mem_rw_i == 2'b01);
                  ram_addr     <= mem_addr_i[11:2];
                  ram_we       <= (mem_rw_i == 2'b10) ? mem_sel_i : 4'd0;
                  ram_wdata    <= mem_data_i;
                  cnt_r        <= LAT_C;
                  ram_en       <= 1'b1;
                  state_r      <= ST_ISSUE;
               end else if (if_req) begin
                  owner_data_r <= 1'b0;
                  capture_r    <= 1'b1;
                  ram_addr     <= if_addr[11:2];
                  ram_we       <= 4'd0;
                  ram_wdata    <= 32'd0;
                  cnt_r        <= LAT_C;
                  ram_en       <= 1'b1;
                  state_r      <= ST_ISSUE;
               end else begin
                  state_r      <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               ram_en  <= 1'b0;
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               cnt_r <= cnt_r - 3'd1;
               // Count of 1 marks the cycle the RAM word is valid on ram_rdata.
               if (cnt_r == 3'd1) begin
                  if (capture_r && owner_data_r) begin
                     mem_rdata <= ram_rdata;
                  end else if (capture_r) begin
                     if_rdata <= ram_rdata;
                  end
                  if (owner_data_r) begin
                     mem_ack <= 1'b1;
                  end else begin
                     if_ack <= 1'b1;
                  end
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               if_ack    <= 1'b0;
               mem_ack   <= 1'b0;
               ram_we    <= 4'd0;
               ram_addr  <= 10'd0;
               ram_wdata <= 32'd0;
               state_r   <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LATENCY=1 and LATENCY=4 instances, each with a RAM
// model, checked against a cycle-count reference model plus directed vectors.
module tb_mem_port_arbiter;
   typedef struct packed {
      logic        rst;
      logic        if_req;
      logic [11:0] if_addr;
      logic [1:0]  rw;
      logic [11:0] maddr;
      logic [3:0]  sel;
      logic [31:0] wd;
   } in_t;

   typedef struct packed {
      logic        ram_en;
      logic [3:0]  ram_we;
      logic [9:0]  ram_addr;
      logic [31:0] ram_wdata;
      logic        if_ack;
      logic        mem_ack;
      logic [31:0] if_rdata;
      logic [31:0] mem_rdata;
      logic        st_if;
      logic        st_mem;
   } out_t;

   typedef struct packed {
      logic        if_req;
      logic [11:0] if_addr;
      logic [1:0]  rw;
      logic [11:0] maddr;
      logic        en;
      logic [9:0]  ra;
      logic        ia;
      logic        ma;
      logic        si;
      logic        sm;
      logic [31:0] ird;
      logic [31:0] mrd;
   } vec_t;

   logic        clk = 1'b0;
   in_t         din [2];
   logic        ram_en_w [2];
   logic [3:0]  ram_we_w [2];
   logic [9:0]  ram_addr_w [2];
   logic [31:0] ram_wdata_w [2];
   logic [31:0] ram_rdata_w [2];
   logic [31:0] if_rdata_w [2];
   logic [31:0] mem_rdata_w [2];
   logic        if_ack_w [2];
   logic        mem_ack_w [2];
   logic        st_if_w [2];
   logic        st_mem_w [2];

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: k counts cycles since the grant (0 = idle).
   int          m_k [2];
   logic        m_owner [2];
   logic        m_isw [2];
   logic [9:0]  m_addr [2];
   logic [3:0]  m_we [2];
   logic [31:0] m_wdata [2];
   logic [31:0] m_ifr [2];
   logic [31:0] m_memr [2];
   logic [31:0] ref_mem [2][1024];
   out_t        exp_o [2];
   vec_t        tbl [15];

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(int j);
      if (j == 4) return 32'h0000_0013;
      return 32'hC0DE_0000 ^ (32'(j) * 32'h0001_0003);
   endfunction

   function automatic int lat_of(int i);
      return (i == 0) ? 1 : 4;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int L = (gi == 0) ? 1 : 4;
      logic [31:0] ram [1024];
      logic [31:0] pipe [4];
      logic        init_done = 1'b0;

      mem_port_arbiter #(.LATENCY(L)) u_dut (
         .clk          (clk),
         .rst          (din[gi].rst),
         .if_req       (din[gi].if_req),
         .if_addr      (din[gi].if_addr),
         .if_rdata     (if_rdata_w[gi]),
         .if_ack       (if_ack_w[gi]),
         .mem_rw_i     (din[gi].rw),
         .mem_addr_i   (din[gi].maddr),
         .mem_sel_i    (din[gi].sel),
         .mem_data_i   (din[gi].wd),
         .mem_rdata    (mem_rdata_w[gi]),
         .mem_ack      (mem_ack_w[gi]),
         .stallreq_if  (st_if_w[gi]),
         .stallreq_mem (st_mem_w[gi]),
         .ram_en       (ram_en_w[gi]),
         .ram_we       (ram_we_w[gi]),
         .ram_addr     (ram_addr_w[gi]),
         .ram_wdata    (ram_wdata_w[gi]),
         .ram_rdata    (ram_rdata_w[gi])
      );

      assign ram_rdata_w[gi] = pipe[L-1];

      // RAM: word read on the strobe appears L cycles later; junk otherwise.
      always @(posedge clk) begin
         if (!init_done) begin
            for (int j = 0; j < 1024; j++) ram[j] <= init_word(j);
            init_done <= 1'b1;
         end else if (ram_en_w[gi]) begin
            for (int b = 0; b < 4; b++)
               if (ram_we_w[gi][b]) ram[ram_addr_w[gi]][8*b +: 8] <= ram_wdata_w[gi][8*b +: 8];
         end
         pipe[0] <= ram_en_w[gi] ? ram[ram_addr_w[gi]] : $urandom;
         for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
      end
   end

   task automatic chk(int i, string name, logic [31:0] a, logic [31:0] e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s inst%0d t=%0t: got %h, expected %h", name, i, $time, a, e);
      end
   endtask

   task automatic model_expect(int i);
      int   L;
      out_t e;
      L = lat_of(i);
      e = '0;
      if (m_k[i] != 0) begin
         e.ram_en    = (m_k[i] == 1);
         e.ram_addr  = m_addr[i];
         e.ram_we    = m_we[i];
         e.ram_wdata = m_wdata[i];
         if (m_k[i] == L + 2) begin
            if (m_owner[i]) e.mem_ack = 1'b1;
            else            e.if_ack  = 1'b1;
         end
      end
      e.if_rdata  = m_ifr[i];
      e.mem_rdata = m_memr[i];
      e.st_if  = din[i].if_req & ~e.if_ack & ~din[i].rst;
      e.st_mem = ((din[i].rw == 2'b01) || (din[i].rw == 2'b10)) & ~e.mem_ack & ~din[i].rst;
      exp_o[i] = e;
   endtask

   task automatic model_step(int i);
      int L;
      L = lat_of(i);
      if (din[i].rst) begin
         m_k[i] = 0; m_ifr[i] = '0; m_memr[i] = '0;
         m_addr[i] = '0; m_we[i] = '0; m_wdata[i] = '0;
      end else if (m_k[i] != 0) begin
         if (m_k[i] == 1 && m_isw[i])
            for (int b = 0; b < 4; b++)
               if (m_we[i][b]) ref_mem[i][m_addr[i]][8*b +: 8] = m_wdata[i][8*b +: 8];
         if (m_k[i] == L + 1 && !m_isw[i]) begin
            if (m_owner[i]) m_memr[i] = ref_mem[i][m_addr[i]];
            else            m_ifr[i]  = ref_mem[i][m_addr[i]];
         end
         if (m_k[i] == L + 2) begin
            m_k[i] = 0; m_addr[i] = '0; m_we[i] = '0; m_wdata[i] = '0;
         end else begin
            m_k[i]++;
         end
      end else if (din[i].rw == 2'b01 || din[i].rw == 2'b10) begin
         m_owner[i] = 1'b1; m_isw[i] = (din[i].rw == 2'b10);
         m_addr[i] = din[i].maddr[11:2];
         m_we[i] = m_isw[i] ? din[i].sel : 4'd0;
         m_wdata[i] = din[i].wd; m_k[i] = 1;
      end else if (din[i].if_req) begin
         m_owner[i] = 1'b0; m_isw[i] = 1'b0;
         m_addr[i] = din[i].if_addr[11:2];
         m_we[i] = 4'd0; m_wdata[i] = 32'd0; m_k[i] = 1;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         model_expect(i);
         chk(i, "ram_en",    32'(ram_en_w[i]),    32'(exp_o[i].ram_en));
         chk(i, "ram_we",    32'(ram_we_w[i]),    32'(exp_o[i].ram_we));
         chk(i, "ram_addr",  32'(ram_addr_w[i]),  32'(exp_o[i].ram_addr));
         chk(i, "ram_wdata", ram_wdata_w[i],      exp_o[i].ram_wdata);
         chk(i, "if_ack",    32'(if_ack_w[i]),    32'(exp_o[i].if_ack));
         chk(i, "mem_ack",   32'(mem_ack_w[i]),   32'(exp_o[i].mem_ack));
         chk(i, "if_rdata",  if_rdata_w[i],       exp_o[i].if_rdata);
         chk(i, "mem_rdata", mem_rdata_w[i],      exp_o[i].mem_rdata);
         chk(i, "stall_if",  32'(st_if_w[i]),     32'(exp_o[i].st_if));
         chk(i, "stall_mem", 32'(st_mem_w[i]),    32'(exp_o[i].st_mem));
      end
   endtask

   task automatic advance();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic rq, logic [11:0] ia, logic [1:0] rw, logic [11:0] ma,
                               logic en, logic [9:0] ra, logic ik, logic mk_, logic si,
                               logic sm, logic [31:0] ird, logic [31:0] mrd);
      vec_t v;
      v.if_req = rq; v.if_addr = ia; v.rw = rw; v.maddr = ma;
      v.en = en; v.ra = ra; v.ia = ik; v.ma = mk_; v.si = si; v.sm = sm;
      v.ird = ird; v.mrd = mrd;
      return v;
   endfunction

   task automatic new_mem(int i, bit go);
      din[i].rw    = go ? ((($urandom % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
      din[i].maddr = 12'($urandom);
      din[i].sel   = (($urandom % 8) == 0) ? 4'd0 : 4'($urandom);
      din[i].wd    = $urandom;
   endtask

   task automatic gen(int i);
      din[i].rst = (($urandom % 300) == 0);
      if (din[i].if_req) begin
         if (exp_o[i].if_ack) begin
            din[i].if_req = 1'($urandom % 2); din[i].if_addr = 12'($urandom);
         end else if (($urandom % 50) == 0) begin
            din[i].if_req = 1'b0;
         end
      end else if (($urandom % 3) == 0) begin
         din[i].if_req = 1'b1; din[i].if_addr = 12'($urandom);
      end
      if (din[i].rw == 2'b01 || din[i].rw == 2'b10) begin
         if (exp_o[i].mem_ack) new_mem(i, 1'($urandom % 2));
         else if (($urandom % 50) == 0) din[i].rw = 2'b00;
      end else if (($urandom % 3) == 0) begin
         new_mem(i, 1'b1);
      end else begin
         din[i].rw = (($urandom % 4) == 0) ? 2'b11 : 2'b00;
      end
   endtask

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 2; i++) begin
         din[i] = '0; din[i].rst = 1'b1; din[i].if_req = 1'b1;
         m_k[i] = 0; m_owner[i] = 1'b0; m_isw[i] = 1'b0; m_addr[i] = '0;
         m_we[i] = '0; m_wdata[i] = '0; m_ifr[i] = '0; m_memr[i] = '0;
         exp_o[i] = '0;
         for (int j = 0; j < 1024; j++) ref_mem[i][j] = init_word(j);
      end
      // Directed LATENCY=1 vectors: fetch, data-before-fetch, opcode 11.
      tbl[0]  = mk(1'b1, 12'h010, 2'b00, 12'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      tbl[1]  = mk(1'b1, 12'h010, 2'b00, 12'h000, 1'b1, 10'h004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      tbl[2]  = mk(1'b1, 12'h010, 2'b00, 12'h000, 1'b0, 10'h004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      tbl[3]  = mk(1'b1, 12'h010, 2'b00, 12'h000, 1'b0, 10'h004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0);
      tbl[4]  = mk(1'b0, 12'h000, 2'b00, 12'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0);
      tbl[5]  = mk(1'b1, 12'h020, 2'b01, 12'h100, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0);
      tbl[6]  = mk(1'b1, 12'h020, 2'b01, 12'h100, 1'b1, 10'h040, 1'b0, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0);
      tbl[7]  = mk(1'b1, 12'h020, 2'b01, 12'h100, 1'b0, 10'h040, 1'b0, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0);
      tbl[8]  = mk(1'b1, 12'h020, 2'b01, 12'h100, 1'b0, 10'h040, 1'b0, 1'b1, 1'b1, 1'b0, 32'h13, init_word(64));
      tbl[9]  = mk(1'b1, 12'h020, 2'b00, 12'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h13, init_word(64));
      tbl[10] = mk(1'b1, 12'h020, 2'b00, 12'h000, 1'b1, 10'h008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h13, init_word(64));
      tbl[11] = mk(1'b1, 12'h020, 2'b00, 12'h000, 1'b0, 10'h008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h13, init_word(64));
      tbl[12] = mk(1'b1, 12'h020, 2'b00, 12'h000, 1'b0, 10'h008, 1'b1, 1'b0, 1'b0, 1'b0, init_word(8), init_word(64));
      tbl[13] = mk(1'b0, 12'h000, 2'b11, 12'h100, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, init_word(8), init_word(64));
      tbl[14] = mk(1'b0, 12'h000, 2'b11, 12'h100, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, init_word(8), init_word(64));

      @(posedge clk); #1;
      sample(); advance();
      sample(); advance();
      din[1].rst = 1'b0; din[1].if_req = 1'b0;
      din[0].rst = 1'b0;

      for (int r = 0; r < 15; r++) begin
         din[0].if_req = tbl[r].if_req; din[0].if_addr = tbl[r].if_addr;
         din[0].rw = tbl[r].rw; din[0].maddr = tbl[r].maddr;
         sample();
         chk(0, "tbl_ram_en",   32'(ram_en_w[0]),   32'(tbl[r].en));
         chk(0, "tbl_ram_addr", 32'(ram_addr_w[0]), 32'(tbl[r].ra));
         chk(0, "tbl_ram_we",   32'(ram_we_w[0]),   32'd0);
         chk(0, "tbl_if_ack",   32'(if_ack_w[0]),   32'(tbl[r].ia));
         chk(0, "tbl_mem_ack",  32'(mem_ack_w[0]),  32'(tbl[r].ma));
         chk(0, "tbl_stall_if", 32'(st_if_w[0]),    32'(tbl[r].si));
         chk(0, "tbl_stall_mem",32'(st_mem_w[0]),   32'(tbl[r].sm));
         chk(0, "tbl_if_rdata", if_rdata_w[0],      tbl[r].ird);
         chk(0, "tbl_mem_rdata",mem_rdata_w[0],     tbl[r].mrd);
         advance();
      end

      // Partial write then readback of the same word.
      din[0].rw = 2'b10; din[0].maddr = 12'h104; din[0].sel = 4'b0011; din[0].wd = 32'hDEAD_BEEF;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) din[0].rw = 2'b00;
         sample();
         if (k == 1) begin
            chk(0, "wr_we",    32'(ram_we_w[0]),   32'h3);
            chk(0, "wr_addr",  32'(ram_addr_w[0]), 32'h041);
            chk(0, "wr_wdata", ram_wdata_w[0],     32'hDEAD_BEEF);
         end
         chk(0, "wr_ack", 32'(mem_ack_w[0]), (k == 3) ? 32'd1 : 32'd0);
         advance();
      end
      w = init_word(65);
      din[0].rw = 2'b01;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) din[0].rw = 2'b00;
         sample();
         if (k == 3) begin
            chk(0, "rb_ack",   32'(mem_ack_w[0]), 32'd1);
            chk(0, "rb_rdata", mem_rdata_w[0],    {w[31:16], 16'hBEEF});
         end
         advance();
      end

      // Reset in the WAIT cycle of a fetch, then the held request is regranted.
      din[0].if_req = 1'b1; din[0].if_addr = 12'h030;
      for (int k = 0; k < 8; k++) begin
         din[0].rst = (k == 2);
         if (k == 7) din[0].if_req = 1'b0;
         sample();
         if (k == 1) chk(0, "rs_issue", 32'(ram_en_w[0]), 32'd1);
         if (k == 2) chk(0, "rs_stall", 32'(st_if_w[0]), 32'd0);
         if (k == 3) begin
            chk(0, "rs_ack",   32'(if_ack_w[0]),   32'd0);
            chk(0, "rs_addr",  32'(ram_addr_w[0]), 32'd0);
            chk(0, "rs_mrd",   mem_rdata_w[0],     32'd0);
         end
         if (k == 4) chk(0, "rs_regrant", 32'(ram_en_w[0]), 32'd1);
         if (k == 6) begin
            chk(0, "rs_ack2",  32'(if_ack_w[0]), 32'd1);
            chk(0, "rs_rdata", if_rdata_w[0],    init_word(12));
         end
         advance();
      end

      // LATENCY=4 read of 0x200.
      din[1].rw = 2'b01; din[1].maddr = 12'h200;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) din[1].rw = 2'b00;
         sample();
         chk(1, "l4_ram_en",  32'(ram_en_w[1]),  (k == 1) ? 32'd1 : 32'd0);
         chk(1, "l4_mem_ack", 32'(mem_ack_w[1]), (k == 6) ? 32'd1 : 32'd0);
         chk(1, "l4_stall",   32'(st_mem_w[1]),  (k <= 5) ? 32'd1 : 32'd0);
         if (k == 6) chk(1, "l4_rdata", mem_rdata_w[1], init_word(128));
         advance();
      end

      for (int c = 0; c < 3000; c++) begin
         gen(0);
         gen(1);
         sample();
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
